sum_window_monitor: RTL and testbench



---
 rtl/sum_monitor_pkg.sv | 16 +
 rtl/sum_minmax_tracker.sv | 59 +++++
 rtl/sum_window_monitor.sv | 173 +++++++++++++++++
 tb/tb_sum_window_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_monitor_pkg.sv
// rtl/sum_monitor_pkg.sv - shared widths and state type for the sum window monitor
// Purpose: common constants for the 10-DUT summation chain and the monitor FSM state type.
// Ports: none (package).
package sum_monitor_pkg;

  localparam int OUTPUT_WIDTH = 8;
  localparam int NUM_DUTS     = 10;
  localparam int SUM_WIDTH    = OUTPUT_WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } win_state_e;

endpackage

// File: rtl/sum_minmax_tracker.sv
// rtl/sum_minmax_tracker.sv - running unsigned min/max of the samples in one window
// Purpose: keeps the smallest and largest accepted sample of the current window.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear_i         window opened: trackers return to 0
//   first_i         current update is the first sample of the window (loads both trackers)
//   update_i        a sample is accepted this cycle
//   sample_i        accepted sample value
//   min_o, max_o    tracker state before this cycle's update
//   min_next_o,
//   max_next_o      tracker values including this cycle's sample
module sum_minmax_tracker #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             first_i,
  input  logic             update_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_next_o,
  output logic [WIDTH-1:0] max_next_o
);

  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  // The first sample must overwrite both trackers regardless of their
  // cleared value, otherwise min would stick at 0.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (update_i) begin
      min_d = (first_i || (sample_i < min_q)) ? sample_i : min_q;
      max_d = (first_i || (sample_i > max_q)) ? sample_i : max_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clear_i) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o      = min_q;
  assign max_o      = max_q;
  assign min_next_o = min_d;
  assign max_next_o = max_d;

endmodule

// File: rtl/sum_window_monitor.sv
// rtl/sum_window_monitor.sv - windowed total/average of the summed DUT outputs
// Purpose: accepts WINDOW_LEN samples per window, reports total and truncated
//   average through a valid/ready result interface, counts completed windows.
// Optional: SUM_WINDOW_MINMAX_EN adds result_min/result_max ports and trackers.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       open a window (IDLE, or REPORT with result handshake)
//   sample_valid/sample_ready   sample handshake; ready only while accumulating
//   sample                      summed DUT outputs
//   result_valid/result_ready   result handshake; valid while reporting
//   result_total, result_avg    window sum and sum >> log2(WINDOW_LEN)
//   busy                        accumulating or reporting
//   windows_done                completed result handshakes, wrapping
//   result_min, result_max      window extremes (SUM_WINDOW_MINMAX_EN only)
module sum_window_monitor #(
  parameter  int SUM_WIDTH  = sum_monitor_pkg::SUM_WIDTH,
  parameter  int WINDOW_LEN = 16,
  parameter  int CNT_WIDTH  = 16,
  localparam int ACC_WIDTH  = SUM_WIDTH + $clog2(WINDOW_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [SUM_WIDTH-1:0] sample,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_WIDTH-1:0] result_total,
  output logic [SUM_WIDTH-1:0] result_avg,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] windows_done
`ifdef SUM_WINDOW_MINMAX_EN
  ,
  output logic [SUM_WIDTH-1:0] result_min,
  output logic [SUM_WIDTH-1:0] result_max
`endif
);

  import sum_monitor_pkg::*;

  localparam int LOG2_WIN = $clog2(WINDOW_LEN);

  win_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LOG2_WIN-1:0]  count_q, count_d;
  logic [ACC_WIDTH-1:0] total_q, total_d;
  logic [SUM_WIDTH-1:0] avg_q, avg_d;
  logic [CNT_WIDTH-1:0] done_q, done_d;

  logic                 sample_hs;
  logic                 last_sample;
  logic                 win_open;
  logic [ACC_WIDTH-1:0] acc_sum;

  assign sample_hs   = (state_q == ACCUM) && sample_valid;
  assign last_sample = (count_q == LOG2_WIN'(WINDOW_LEN - 1));
  // ACC_WIDTH holds WINDOW_LEN full-scale samples, so this add cannot overflow.
  assign acc_sum     = acc_q + ACC_WIDTH'(sample);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    total_d  = total_q;
    avg_d    = avg_q;
    done_d   = done_q;
    win_open = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCUM;
          acc_d    = '0;
          count_d  = '0;
          win_open = 1'b1;
        end
      end
      ACCUM: begin
        if (sample_hs) begin
          acc_d   = acc_sum;
          count_d = count_q + LOG2_WIN'(1);
          if (last_sample) begin
            total_d = acc_sum;
            // Upper slice is exactly SUM_WIDTH wide: the truncating divide.
            avg_d   = acc_sum[ACC_WIDTH-1:LOG2_WIN];
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (result_ready) begin
          done_d = done_q + CNT_WIDTH'(1);
          if (start) begin
            // Back-to-back window: skip IDLE so no sample cycle is lost.
            state_d  = ACCUM;
            acc_d    = '0;
            count_d  = '0;
            win_open = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      total_q <= '0;
      avg_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      total_q <= total_d;
      avg_q   <= avg_d;
      done_q  <= done_d;
    end
  end

  assign sample_ready = (state_q == ACCUM);
  assign result_valid = (state_q == REPORT);
  assign busy         = (state_q != IDLE);
  assign result_total = total_q;
  assign result_avg   = avg_q;
  assign windows_done = done_q;

`ifdef SUM_WINDOW_MINMAX_EN
  logic [SUM_WIDTH-1:0] trk_min, trk_max, trk_min_next, trk_max_next;
  logic [SUM_WIDTH-1:0] rmin_q, rmax_q;

  sum_minmax_tracker #(
    .WIDTH(SUM_WIDTH)
  ) u_minmax (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (win_open),
    .first_i   (count_q == '0),
    .update_i  (sample_hs),
    .sample_i  (sample),
    .min_o     (trk_min),
    .max_o     (trk_max),
    .min_next_o(trk_min_next),
    .max_next_o(trk_max_next)
  );

  // Latch the values that already include the final sample of the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmin_q <= '0;
      rmax_q <= '0;
    end else if (sample_hs && last_sample) begin
      rmin_q <= trk_min_next;
      rmax_q <= trk_max_next;
    end
  end

  logic unused_trk;
  assign unused_trk = ^{trk_min, trk_max};

  assign result_min = rmin_q;
  assign result_max = rmax_q;
`else
  logic unused_open;
  assign unused_open = win_open;
`endif

endmodule

// File: tb/tb_sum_window_monitor.sv
// tb/tb_sum_window_monitor.sv - self-checking bench for sum_window_monitor
module tb_sum_window_monitor;

  localparam int WIN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [11:0] sample = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [15:0] result_total;
  logic [11:0] result_avg;
  logic        busy;
  logic [15:0] windows_done;
`ifdef SUM_WINDOW_MINMAX_EN
  logic [11:0] result_min;
  logic [11:0] result_max;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sum_window_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample      (sample),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_total(result_total),
    .result_avg  (result_avg),
    .busy        (busy),
    .windows_done(windows_done)
`ifdef SUM_WINDOW_MINMAX_EN
    ,
    .result_min  (result_min),
    .result_max  (result_max)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = no window, 1 = collecting, 2 = result pending.
  int m_phase = 0;
  int m_q[$];
  int m_total = 0, m_avg = 0, m_min = 0, m_max = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_q.delete();
      m_total = 0; m_avg = 0; m_min = 0; m_max = 0; m_done = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_q.delete(); end
        1: if (sample_valid) begin
             m_q.push_back(int'(sample));
             if (m_q.size() == WIN) begin
               m_total = 0; m_min = m_q[0]; m_max = m_q[0];
               foreach (m_q[k]) begin
                 m_total += m_q[k];
                 if (m_q[k] < m_min) m_min = m_q[k];
                 if (m_q[k] > m_max) m_max = m_q[k];
               end
               m_avg = m_total / WIN;
               m_phase = 2;
             end
           end
        default: if (result_ready) begin
             m_done = (m_done + 1) % 65536;
             m_q.delete();
             m_phase = start ? 1 : 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_result_valid", int'(result_valid), int'(m_phase == 2));
      chk("cmp_sample_ready", int'(sample_ready), int'(m_phase == 1));
      chk("cmp_busy", int'(busy), int'(m_phase != 0));
      chk("cmp_windows_done", int'(windows_done), m_done);
      chk("cmp_total", int'(result_total), m_total);
      chk("cmp_avg", int'(result_avg), m_avg);
`ifdef SUM_WINDOW_MINMAX_EN
      chk("cmp_min", int'(result_min), m_min);
      chk("cmp_max", int'(result_max), m_max);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample = 12'(v);
    tick();
  endtask

  task automatic accept(input logic restart);
    result_ready = 1'b1;
    start = restart;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_ready", int'(sample_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_total", int'(result_total), 0);
    chk("rst_done", int'(windows_done), 0);
    rst = 1'b0;
    tick();

    // 1: constant 100
    do_start();
    for (int i = 0; i < WIN; i++) send(100);
    sample_valid = 1'b0;
    chk("t1_valid", int'(result_valid), 1);
    chk("t1_total", int'(result_total), 1600);
    chk("t1_avg", int'(result_avg), 100);
    chk("t1_done_before", int'(windows_done), 0);
    tick();
    chk("t1_valid_held", int'(result_valid), 1);
    accept(1'b0);
    chk("t1_done_after", int'(windows_done), 1);
    chk("t1_idle", int'(busy), 0);

    // 2: full scale, then ramp with back-to-back start
    do_start();
    for (int i = 0; i < WIN; i++) send(4095);
    sample_valid = 1'b0;
    chk("t2_total_max", int'(result_total), 65520);
    chk("t2_avg_max", int'(result_avg), 4095);
    accept(1'b1);
    chk("t2_b2b_ready", int'(sample_ready), 1);
    for (int i = 0; i < WIN; i++) send(i);
    sample_valid = 1'b0;
    chk("t2_total_ramp", int'(result_total), 120);
    chk("t2_avg_trunc", int'(result_avg), 7);
    accept(1'b0);

    // 3: stall in REPORT with noise on sample/start
    do_start();
    for (int i = 0; i < WIN; i++) send(200);
    sample = 12'd999;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", int'(result_valid), 1);
      chk("t3_hold_ready", int'(sample_ready), 0);
      chk("t3_hold_total", int'(result_total), 3200);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    chk("t3_restart_ready", int'(sample_ready), 1);
    for (int i = 0; i < WIN; i++) send(5);
    sample_valid = 1'b0;
    chk("t3_total_next", int'(result_total), 80);
    accept(1'b0);
    chk("t3_done", int'(windows_done), 5);

    // 4: asynchronous reset mid-window
    do_start();
    for (int i = 0; i < 7; i++) send(50);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", int'(result_valid), 0);
    chk("t4_rst_ready", int'(sample_ready), 0);
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_total", int'(result_total), 0);
    chk("t4_rst_avg", int'(result_avg), 0);
    chk("t4_rst_done", int'(windows_done), 0);
    sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_start();
    for (int i = 0; i < WIN; i++) send(1);
    sample_valid = 1'b0;
    chk("t4_total_ones", int'(result_total), 16);
    accept(1'b0);

    // 5: valid every third cycle, start pulses during accumulation
    do_start();
    for (int i = 0; i < WIN; i++) begin
      sample_valid = 1'b1;
      sample = 12'(10 + i);
      tick();
      sample_valid = 1'b0;
      sample = 12'd777;
      if (i == WIN - 2) chk("t5_not_yet", int'(result_valid), 0);
      start = (i % 4 == 1);
      if (i != WIN - 1) begin
        tick();
        start = 1'b0;
        tick();
      end
    end
    start = 1'b0;
    chk("t5_total", int'(result_total), 280);
    chk("t5_avg", int'(result_avg), 17);
    accept(1'b0);

`ifdef SUM_WINDOW_MINMAX_EN
    // 6: min/max tracking and first-sample load
    do_start();
    for (int i = 0; i < WIN; i++) begin
      case (i % 4)
        0: send(50);
        1: send(3);
        2: send(900);
        default: send(7);
      endcase
    end
    sample_valid = 1'b0;
    chk("t6_min", int'(result_min), 3);
    chk("t6_max", int'(result_max), 900);
    accept(1'b1);
    for (int i = 0; i < WIN; i++) send(20);
    sample_valid = 1'b0;
    chk("t6_min_flat", int'(result_min), 20);
    chk("t6_max_flat", int'(result_max), 20);
    accept(1'b0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
